idx_vec_builder: RTL and testbench
==================================

# idx_vec_builder

Streaming index-to-vector builder: the inverse of the zero-counter/priority-encoder path. Accepts a burst of index beats (each an index plus an empty flag, exactly as the counter emits them) over a valid/ready handshake. Sets the corresponding bit for each beat and, on the last beat, presents the assembled vector on a registered valid/ready output. Used to rebuild entry-match masks from serialized entry indices, e.g. for the error-record and priority-check paths.

## Interface
- `WIDTH`, default 8: vector width, ≥ 1.
- `MODE`, default 1'b0: 0 → index counts from LSB (bit `idx`); 1 → index counts from MSB (bit `WIDTH-1-idx`).
- `CNT_WIDTH`, default `cf_math_pkg::idx_width(WIDTH)`: index width. Dependent; do not override.
- `clk_i`  in  1  clock. One clock domain.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `in_valid_i`  in  1  index beat valid.
- `in_ready_o`  out  1  index beat accepted when high with `in_valid_i`.
- `in_idx_i`  in  CNT_WIDTH  bit index.
- `in_empty_i`  in  1  beat carries no index; `in_idx_i` is ignored.
- `in_last_i`  in  1  final beat of the burst.
- `out_valid_o`  out  1  assembled vector valid.
- `out_ready_i`  in  1  consumer accepts vector.
- `out_vec_o`  out  WIDTH  assembled vector.
- `out_empty_o`  out  1  no bit set in `out_vec_o`.
- `out_dup_o`  out  1  at least one index in the burst hit an already-set bit.
- `out_err_o`  out  1  at least one non-empty beat had `in_idx_i >= WIDTH`.

## Operation
- States: COLLECT (reset) and HOLD.
- COLLECT:
  - `in_ready_o = 1`, `out_valid_o = 0`.
  - Each accepted beat updates the accumulator:
    - Non-empty, in-range beat: OR in the one-hot for the mapped bit.
    - Bit already set (in the accumulator): set sticky dup.
    - `idx >= WIDTH`: set sticky err; vector unchanged.
    - `in_empty_i = 1`: no vector/dup/err change.
  - Beat with `in_last_i` → move to HOLD. The output registers capture the accumulator including that beat.
- HOLD:
  - `out_valid_o = 1`, `in_ready_o = 0`.
  - Outputs stable until `out_ready_i`.
  - On handshake: clear accumulator, dup and err; return to COLLECT.
- `out_empty_o = ~|out_vec_o`, registered with the vector.
- A one-beat burst (`in_last_i` on first beat) is legal.
- A burst of only empty beats yields vec 0, `out_empty_o = 1`.
- `WIDTH == 1`: `CNT_WIDTH = 1`; idx 1 is out of range.

## Timing
- Reset values:
  - `out_valid_o = 0`, `out_vec_o = 0`, `out_empty_o = 1`, `out_dup_o = 0`, `out_err_o = 0`.
  - `in_ready_o = 1` (COLLECT), accumulator cleared.
- Latency: last beat accepted in cycle t → `out_valid_o` high in t+1.
- Throughput: an N-beat burst occupies N cycles in COLLECT plus ≥1 cycle in HOLD. With `out_ready_i` tied high, the next burst's first beat is accepted at t+2.
- `in_ready_o` depends only on state, never combinationally on `out_ready_i`. No combinational path from input to output.
- Reset mid-burst or mid-HOLD: partial accumulation and pending output are discarded; all outputs return to reset values next cycle.
- `in_*` are ignored whenever `in_ready_o = 0`.

## Structure
- State enum typedef is local to the module.
- Index width comes from `cf_math_pkg::idx_width`; no new package is needed.
- One natural combinational sub-module: `idx_onehot_dec` (index + MODE → WIDTH-bit one-hot plus out-of-range flag). It is reusable by other mask builders.
- Accumulator, sticky flags and output registers live in `idx_vec_builder`.

## Test plan
- WIDTH=7, MODE=0:
  - Beats idx 0, idx 3 (last) → `out_vec_o = 7'b0001001`, empty/dup/err = 0. `out_valid_o` rises one cycle after the last handshake.
  - Beats idx 2, idx 2 (last) → vec `7'b0000100`, `out_dup_o = 1`.
  - Beat idx 7 (last) → vec 0, `out_err_o = 1`, `out_empty_o = 1`.
- WIDTH=7, MODE=1: beats idx 0, idx 6 (last) → vec `7'b1000001`. A single empty beat (last) → vec 0, `out_empty_o = 1`, err = 0.
- Backpressure:
  - Hold `out_ready_i = 0` for 4 cycles after a burst. `out_vec_o`/flags stay stable and `in_ready_o = 0` throughout; offered beats are not consumed.
  - Release → next burst accepted one cycle later, accumulator clear.
- Reset mid-burst:
  - Accept idx 1, idx 4 (not last), assert `rst_ni = 0` for one cycle, then send idx 5 (last).
  - Required result: vec `7'b0100000` only, flags 0.
- Random regression (WIDTH ∈ {1, 5, 8, 33}, both MODEs): for every burst, check that `out_vec_o` matches a scoreboard OR of mapped indices. Also check that running the reference zero counter on `out_vec_o` reproduces the lowest index sent whenever exactly one index is in the burst.

Source files
------------

// File: rtl/cf_math_pkg.sv
// Shared math helpers for index/count widths.
// idx_width gives the bits needed to address num_idx entries.
package cf_math_pkg;

  function automatic int unsigned idx_width(
    input int unsigned num_idx
  );
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Index to one-hot decoder with out-of-range flag.
// MODE 0 maps idx to bit idx, MODE 1 to bit WIDTH-1-idx.
module idx_onehot_dec
  import cf_math_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = idx_width(WIDTH)
) (
  input  logic [CNT_WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0]     onehot_o,
  output logic                 oor_o
);

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx_i);
  assign oor_o   = (idx_ext >= WIDTH);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int unsigned POS =
      MODE ? (WIDTH - 1 - i) : i;
    assign onehot_o[i] = (idx_ext == POS);
  end

endmodule

// File: rtl/idx_vec_builder.sv
// Streaming builder: index beats in, assembled bit vector out.
// Sticky dup/err flags travel with the vector.
module idx_vec_builder
  import cf_math_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = idx_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CNT_WIDTH-1:0] in_idx_i,
  input  logic                 in_empty_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_vec_o,
  output logic                 out_empty_o,
  output logic                 out_dup_o,
  output logic                 out_err_o
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_vec_q;
  logic             acc_dup_q;
  logic             acc_err_q;
  logic [WIDTH-1:0] out_vec_q;
  logic             out_empty_q;
  logic             out_dup_q;
  logic             out_err_q;

  logic [WIDTH-1:0] dec_onehot;
  logic             dec_oor;
  logic             hit;
  logic [WIDTH-1:0] nxt_vec;
  logic             nxt_dup;
  logic             nxt_err;

  idx_onehot_dec #(
    .WIDTH    (WIDTH),
    .MODE     (MODE),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_dec (
    .idx_i   (in_idx_i),
    .onehot_o(dec_onehot),
    .oor_o   (dec_oor)
  );

  // Accumulator value if the current beat were accepted.
  always_comb begin
    hit     = ~in_empty_i & ~dec_oor;
    nxt_vec = acc_vec_q | (hit ? dec_onehot : '0);
    nxt_dup = acc_dup_q |
              (hit & |(acc_vec_q & dec_onehot));
    nxt_err = acc_err_q | (~in_empty_i & dec_oor);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= COLLECT;
      acc_vec_q   <= '0;
      acc_dup_q   <= 1'b0;
      acc_err_q   <= 1'b0;
      out_vec_q   <= '0;
      out_empty_q <= 1'b1;
      out_dup_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid_i) begin
            acc_vec_q <= nxt_vec;
            acc_dup_q <= nxt_dup;
            acc_err_q <= nxt_err;
            if (in_last_i) begin
              out_vec_q   <= nxt_vec;
              out_empty_q <= ~|nxt_vec;
              out_dup_q   <= nxt_dup;
              out_err_q   <= nxt_err;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            acc_vec_q <= '0;
            acc_dup_q <= 1'b0;
            acc_err_q <= 1'b0;
            state_q   <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready_o  = (state_q == COLLECT);
  assign out_valid_o = (state_q == HOLD);
  assign out_vec_o   = out_vec_q;
  assign out_empty_o = out_empty_q;
  assign out_dup_o   = out_dup_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_idx_vec_builder.sv
// Directed and randomized bench for idx_vec_builder.
// Instances 0/1 are WIDTH=7; 2..9 cover WIDTH 1,5,8,33.
module tb_idx_vec_builder;
  import cf_math_pkg::*;

  localparam int N = 10;

  function automatic int cfg_w(input int g);
    case (g)
      0, 1:    return 7;
      2, 3:    return 1;
      4, 5:    return 5;
      6, 7:    return 8;
      default: return 33;
    endcase
  endfunction

  function automatic bit cfg_m(input int g);
    return (g % 2) == 1;
  endfunction

  // Reference zero counter: trailing zeros (MODE 0)
  // or leading zeros (MODE 1) within w bits.
  function automatic int zc(
    input logic [32:0] v, input int w, input bit m
  );
    for (int i = 0; i < w; i++) begin
      if (m ? v[w-1-i] : v[i]) return i;
    end
    return w;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  [N];
  logic        in_empty  [N];
  logic        in_last   [N];
  logic        out_ready [N];
  logic [5:0]  in_idx    [N];
  logic        in_ready  [N];
  logic        out_valid [N];
  logic        out_empty [N];
  logic        out_dup   [N];
  logic        out_err   [N];
  logic [32:0] out_vec   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W  = cfg_w(g);
    localparam bit M  = cfg_m(g);
    localparam int CW = int'(idx_width(W));
    logic [W-1:0] vec;
    logic rdy, vld, emp, dup, err;

    idx_vec_builder #(
      .WIDTH(W),
      .MODE (M)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid[g]),
      .in_ready_o (rdy),
      .in_idx_i   (in_idx[g][CW-1:0]),
      .in_empty_i (in_empty[g]),
      .in_last_i  (in_last[g]),
      .out_valid_o(vld),
      .out_ready_i(out_ready[g]),
      .out_vec_o  (vec),
      .out_empty_o(emp),
      .out_dup_o  (dup),
      .out_err_o  (err)
    );

    assign out_vec[g]   = 33'(vec);
    assign in_ready[g]  = rdy;
    assign out_valid[g] = vld;
    assign out_empty[g] = emp;
    assign out_dup[g]   = dup;
    assign out_err[g]   = err;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic beat(
    input int g, input int idx,
    input bit emp, input bit last
  );
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    in_idx[g]   = 6'(idx);
    in_empty[g] = emp;
    in_last[g]  = last;
    while (!in_ready[g] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("beat_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    in_empty[g] = 1'b0;
    in_last[g]  = 1'b0;
  endtask

  task automatic take(
    input int g, input string tag,
    input logic [32:0] ev,
    input bit ee, input bit ed, input bit er
  );
    int n;
    n = 0;
    while (!out_valid[g] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_vld"}, 64'(out_valid[g]), 64'd1);
    chk({tag, "_vec"}, 64'(out_vec[g]), 64'(ev));
    chk({tag, "_emp"}, 64'(out_empty[g]), 64'(ee));
    chk({tag, "_dup"}, 64'(out_dup[g]), 64'(ed));
    chk({tag, "_err"}, 64'(out_err[g]), 64'(er));
  endtask

  task automatic consume(input int g);
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    out_ready[g] = 1'b0;
  endtask

  initial begin
    int w, cw, len, idx, p, nidx, first;
    bit m, emp, ed, er;
    logic [32:0] ev;

    for (int g = 0; g < N; g++) begin
      in_valid[g]  = 1'b0;
      in_empty[g]  = 1'b0;
      in_last[g]   = 1'b0;
      out_ready[g] = 1'b0;
      in_idx[g]    = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_vld", 64'(out_valid[0]), 64'd0);
    chk("rst_vec", 64'(out_vec[0]), 64'd0);
    chk("rst_emp", 64'(out_empty[0]), 64'd1);
    chk("rst_dup", 64'(out_dup[0]), 64'd0);
    chk("rst_err", 64'(out_err[0]), 64'd0);
    chk("rst_rdy", 64'(in_ready[0]), 64'd1);

    // Basic burst plus latency.
    beat(0, 0, 1'b0, 1'b0);
    chk("lat_pre", 64'(out_valid[0]), 64'd0);
    beat(0, 3, 1'b0, 1'b1);
    chk("lat_t1", 64'(out_valid[0]), 64'd1);
    take(0, "b03", 33'b0001001, 1'b0, 1'b0, 1'b0);
    consume(0);

    beat(0, 2, 1'b0, 1'b0);
    beat(0, 2, 1'b0, 1'b1);
    take(0, "dup", 33'b0000100, 1'b0, 1'b1, 1'b0);
    consume(0);

    beat(0, 7, 1'b0, 1'b1);
    take(0, "oor", 33'd0, 1'b1, 1'b0, 1'b1);
    consume(0);

    // MODE 1 mapping and an empty-only burst.
    beat(1, 0, 1'b0, 1'b0);
    beat(1, 6, 1'b0, 1'b1);
    take(1, "msb", 33'b1000001, 1'b0, 1'b0, 1'b0);
    consume(1);
    beat(1, 7, 1'b1, 1'b1);
    take(1, "mty", 33'd0, 1'b1, 1'b0, 1'b0);
    consume(1);

    // Backpressure with a beat offered during HOLD.
    beat(0, 1, 1'b0, 1'b0);
    beat(0, 4, 1'b0, 1'b1);
    in_valid[0] = 1'b1;
    in_idx[0]   = 6'd5;
    in_last[0]  = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_rdy", 64'(in_ready[0]), 64'd0);
      chk("bp_vld", 64'(out_valid[0]), 64'd1);
      chk("bp_vec", 64'(out_vec[0]), 64'b0010010);
      chk("bp_dup", 64'(out_dup[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("rel_vld", 64'(out_valid[0]), 64'd0);
    chk("rel_rdy", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    take(0, "rel", 33'b0100000, 1'b0, 1'b0, 1'b0);
    consume(0);

    // Back-to-back with consumer always ready.
    out_ready[0] = 1'b1;
    beat(0, 6, 1'b0, 1'b1);
    chk("b2b_v1", 64'(out_vec[0]), 64'b1000000);
    in_valid[0] = 1'b1;
    in_idx[0]   = 6'd0;
    in_last[0]  = 1'b1;
    @(posedge clk); #1;
    chk("b2b_rdy", 64'(in_ready[0]), 64'd1);
    chk("b2b_gap", 64'(out_valid[0]), 64'd0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    chk("b2b_vld", 64'(out_valid[0]), 64'd1);
    chk("b2b_v2", 64'(out_vec[0]), 64'b0000001);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset mid-burst discards partial bits.
    beat(0, 1, 1'b0, 1'b0);
    beat(0, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rmb_vld", 64'(out_valid[0]), 64'd0);
    chk("rmb_rdy", 64'(in_ready[0]), 64'd1);
    beat(0, 5, 1'b0, 1'b1);
    take(0, "rmb", 33'b0100000, 1'b0, 1'b0, 1'b0);

    // Reset during HOLD drops the pending vector.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rmh_vld", 64'(out_valid[0]), 64'd0);
    chk("rmh_vec", 64'(out_vec[0]), 64'd0);
    chk("rmh_emp", 64'(out_empty[0]), 64'd1);

    // Random regression against a scoreboard.
    for (int g = 2; g < N; g++) begin
      w  = cfg_w(g);
      m  = cfg_m(g);
      cw = int'(idx_width(w));
      for (int b = 0; b < 12; b++) begin
        len   = $urandom_range(1, 4);
        ev    = '0;
        ed    = 1'b0;
        er    = 1'b0;
        nidx  = 0;
        first = 0;
        for (int k = 0; k < len; k++) begin
          emp = ($urandom_range(0, 4) == 0);
          idx = $urandom_range(0, (1 << cw) - 1);
          if (!emp) begin
            if (idx >= w) begin
              er = 1'b1;
            end else begin
              p = m ? (w - 1 - idx) : idx;
              if (ev[p]) ed = 1'b1;
              ev[p] = 1'b1;
              nidx++;
              first = idx;
            end
          end
          beat(g, idx, emp, k == len - 1);
        end
        take(g, "rnd", ev, ev == '0, ed, er);
        if (nidx == 1)
          chk("rnd_zc", 64'(zc(out_vec[g], w, m)),
              64'(first));
        consume(g);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
